// File: rtl/entry_conditioner.sv
// entry_conditioner: synchronises and debounces the active-low insere push-button
// and the 4-bit numero switches; each clean press yields one validated digit on a
// valid/ready handshake.
// Optional feature macro: LONG_PRESS_CLEAR_EN (long press pulses clear_req and
// flushes the pending digit and overrun flag).
module entry_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned LONG_CYCLES     = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       insere_n,
    input  logic [3:0] numero_raw,
    output logic [3:0] digit,
    output logic       digit_valid,
    input  logic       digit_ready,
    output logic       digit_reject,
    output logic       overrun,
    output logic       pressed,
    output logic       clear_req
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("entry_conditioner: DEBOUNCE_CYCLES must be at least 2");
    end
    if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
        $error("entry_conditioner: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [DW-1:0] cnt;
    logic [DW-1:0] cnt_next;
    logic          accept;
    logic          long_hit;

    logic          s_n_meta;
    logic          s_n;
    logic [3:0]    s_num_meta;
    logic [3:0]    s_num;

    // Two-flop synchronisers for the asynchronous button and switches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_n_meta   <= 1'b1;
            s_n        <= 1'b1;
            s_num_meta <= '0;
            s_num      <= '0;
        end else begin
            s_n_meta   <= insere_n;
            s_n        <= s_n_meta;
            s_num_meta <= numero_raw;
            s_num      <= s_num_meta;
        end
    end

    // Debounce state and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic; a press or release needs DEBOUNCE_CYCLES+1 equal samples
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (!s_n) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = DW'(1);
                end
            end
            PRESS_WAIT: begin
                if (s_n) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == DB_MAX) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                    accept     = 1'b1;
                end else begin
                    cnt_next = cnt + DW'(1);
                end
            end
            PRESSED: begin
                if (s_n) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = DW'(1);
                end
            end
            RELEASE_WAIT: begin
                if (!s_n) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt == DB_MAX) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + DW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign pressed = (state == PRESSED) || (state == RELEASE_WAIT);

`ifdef LONG_PRESS_CLEAR_EN
    localparam int unsigned LW = $clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES);
    localparam logic [LW-1:0] LONG_M1  = LW'(LONG_CYCLES - 1);

    logic [LW-1:0] long_cnt;

    // Hit fires on the increment that reaches LONG_CYCLES; saturation makes it once per press
    assign long_hit = (state == PRESSED) && !s_n && (long_cnt == LONG_M1);

    // Hold-time counter: survives release bounces, cleared only when the release is accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            long_cnt <= '0;
        end else if ((state == RELEASE_WAIT) && s_n && (cnt == DB_MAX)) begin
            long_cnt <= '0;
        end else if ((state == PRESSED) && !s_n && (long_cnt != LONG_MAX)) begin
            long_cnt <= long_cnt + LW'(1);
        end
    end

    // Long-press clear request pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clear_req <= 1'b0;
        end else begin
            clear_req <= long_hit;
        end
    end
`else
    assign long_hit  = 1'b0;
    assign clear_req = 1'b0;
`endif

    // Digit register, handshake, reject pulse and sticky overrun
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit        <= '0;
            digit_valid  <= 1'b0;
            digit_reject <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            digit_reject <= 1'b0;
            if (digit_ready) begin
                digit_valid <= 1'b0;
            end
            if (accept) begin
                if (s_num > 4'd9) begin
                    digit_reject <= 1'b1;
                end else if (digit_valid && !digit_ready) begin
                    overrun <= 1'b1;
                end else begin
                    digit       <= s_num;
                    digit_valid <= 1'b1;
                end
            end
            if (long_hit) begin
                overrun     <= 1'b0;
                digit_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_entry_conditioner.sv
// Self-checking bench for entry_conditioner (DEBOUNCE_CYCLES=4, LONG_CYCLES=20).
// Reference model works on runs of equal synchronised samples and a pending-digit slot.
module tb_entry_conditioner;

    localparam int unsigned DB = 4;
    localparam int unsigned LG = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       insere_n;
    logic [3:0] numero_raw;
    logic       digit_ready;
    logic [3:0] digit;
    logic       digit_valid;
    logic       digit_reject;
    logic       overrun;
    logic       pressed;
    logic       clear_req;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // reference model state
    logic       m_meta, m_sn, prev_s, level;
    logic [3:0] m_nmeta, m_snum, m_digit;
    logic       m_valid, m_rej, m_ovr, m_clr;
    int         run_lo, run_hi, hold_cnt;

    logic [8:0] obs;
    logic [8:0] expv;
    assign obs  = {digit, digit_valid, digit_reject, overrun, pressed, clear_req};
    assign expv = {m_digit, m_valid, m_rej, m_ovr, level, m_clr};

    entry_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LG)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .insere_n    (insere_n),
        .numero_raw  (numero_raw),
        .digit       (digit),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .digit_reject(digit_reject),
        .overrun     (overrun),
        .pressed     (pressed),
        .clear_req   (clear_req)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_meta = 1'b1; m_sn = 1'b1; m_nmeta = '0; m_snum = '0;
        prev_s = 1'b1; level = 1'b0;
        run_lo = 0; run_hi = 0; hold_cnt = 0;
        m_digit = '0; m_valid = 1'b0; m_rej = 1'b0; m_ovr = 1'b0; m_clr = 1'b0;
    endtask

    task automatic model_edge();
        logic       s     = m_sn;
        logic [3:0] num   = m_snum;
        logic       acc   = 1'b0;
        logic       hit   = 1'b0;
        logic       old_v = m_valid;
        if (!s) begin run_lo++; run_hi = 0; end
        else    begin run_hi++; run_lo = 0; end
        if (level) begin
            if (!s && !prev_s && hold_cnt < LG) begin
                hold_cnt++;
                if (hold_cnt == LG) hit = 1'b1;
            end
            if (run_hi == DB + 1) begin level = 1'b0; hold_cnt = 0; end
        end else if (run_lo == DB + 1) begin
            level = 1'b1; acc = 1'b1;
        end
        m_rej = 1'b0; m_clr = 1'b0;
        if (old_v && digit_ready) m_valid = 1'b0;
        if (acc) begin
            if (num > 9) m_rej = 1'b1;
            else if (old_v && !digit_ready) m_ovr = 1'b1;
            else begin m_digit = num; m_valid = 1'b1; end
        end
`ifdef LONG_PRESS_CLEAR_EN
        if (hit) begin m_clr = 1'b1; m_ovr = 1'b0; m_valid = 1'b0; end
`endif
        prev_s  = s;
        m_sn    = m_meta;  m_meta  = insere_n;
        m_snum  = m_nmeta; m_nmeta = numero_raw;
    endtask

    // drive at negedge, clock once, return at the following negedge
    task automatic cycle(input logic n, input logic [3:0] num, input logic rdy);
        insere_n = n; numero_raw = num; digit_ready = rdy;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; insere_n = 1'b1; numero_raw = '0; digit_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (obs !== 9'h000) begin n_bad++; $display("FAIL reset_state: got %h expected %h", obs, 9'h000); end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 4'd3, 1'b0);
            n_cmp++;
            if (obs !== expv) begin n_bad++; $display("FAIL reset_idle: got %h expected %h", obs, expv); end
        end
    endtask

    task automatic test_clean_press();
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b0, 4'd5, 1'b0);
            n_cmp++;
            if (obs !== expv) begin n_bad++; $display("FAIL clean_press cyc %0d: got %h expected %h", i, obs, expv); end
            if (i == 6) begin
                n_cmp++;
                if ({digit_valid, pressed} !== 2'b00) begin n_bad++; $display("FAIL clean_early: got %b expected 00", {digit_valid, pressed}); end
            end
            if (i == 7) begin
                n_cmp++;
                if ({digit, digit_valid, pressed} !== 6'b0101_1_1) begin n_bad++; $display("FAIL clean_accept: got %b expected 010111", {digit, digit_valid, pressed}); end
            end
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 4'd0, 1'b0);
            n_cmp++;
            if (obs !== expv) begin n_bad++; $display("FAIL clean_release: got %h expected %h", obs, expv); end
        end
        n_cmp++;
        if ({digit_valid, pressed} !== 2'b10) begin n_bad++; $display("FAIL clean_hold: got %b expected 10", {digit_valid, pressed}); end
        cycle(1'b1, 4'd0, 1'b1);
        n_cmp++;
        if (digit_valid !== 1'b0) begin n_bad++; $display("FAIL clean_consume: got %b expected 0", digit_valid); end
    endtask

    task automatic test_bounce();
        logic pat [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 6; i++) begin
                cycle(pat[i], 4'd2, 1'b0);
                n_cmp++;
                if (obs !== expv || digit_valid !== 1'b0 || pressed !== 1'b0) begin
                    n_bad++; $display("FAIL bounce: got %h expected %h", obs, expv);
                end
            end
        end
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 4'd2, 1'b0);
            n_cmp++;
            if (obs !== expv) begin n_bad++; $display("FAIL bounce_press: got %h expected %h", obs, expv); end
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 4'd2, 1'b0);
            n_cmp++;
            if (obs !== expv) begin n_bad++; $display("FAIL bounce_release: got %h expected %h", obs, expv); end
        end
        n_cmp++;
        if ({digit, digit_valid, overrun} !== 6'b0010_1_0) begin n_bad++; $display("FAIL bounce_one_digit: got %b expected 001010", {digit, digit_valid, overrun}); end
        cycle(1'b1, 4'd0, 1'b1);
    endtask

    task automatic test_reject();
        int rej = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 4'd12, 1'b0);
            if (digit_reject) rej++;
            n_cmp++;
            if (obs !== expv) begin n_bad++; $display("FAIL reject: got %h expected %h", obs, expv); end
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 4'd12, 1'b0);
            if (digit_reject) rej++;
        end
        n_cmp++;
        if (rej != 1 || digit_valid !== 1'b0 || digit !== 4'd2) begin
            n_bad++; $display("FAIL reject_once: got pulses=%0d valid=%b digit=%0d expected 1/0/2", rej, digit_valid, digit);
        end
    endtask

    task automatic press_release(input logic [3:0] num, input int ready_at);
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, num, (i == ready_at) ? 1'b1 : 1'b0);
            n_cmp++;
            if (obs !== expv) begin n_bad++; $display("FAIL press_seq %0d: got %h expected %h", num, obs, expv); end
        end
        for (int i = 0; i < 8; i++) cycle(1'b1, num, 1'b0);
    endtask

    task automatic test_overrun();
        press_release(4'd1, 0);
        press_release(4'd7, 0);
        n_cmp++;
        if ({digit, digit_valid, overrun} !== 6'b0001_1_1) begin n_bad++; $display("FAIL overrun_set: got %b expected 000111", {digit, digit_valid, overrun}); end
        pulse_reset();
        press_release(4'd1, 0);
        press_release(4'd7, 7);
        n_cmp++;
        if ({digit, digit_valid, overrun} !== 6'b0111_1_0) begin n_bad++; $display("FAIL overrun_handshake: got %b expected 011110", {digit, digit_valid, overrun}); end
    endtask

    task automatic test_long_press();
        int clears = 0;
        for (int i = 1; i <= 40; i++) begin
            cycle(1'b0, 4'd4, 1'b0);
            n_cmp++;
            if (obs !== expv) begin n_bad++; $display("FAIL long_press cyc %0d: got %h expected %h", i, obs, expv); end
            if (clear_req) begin
                clears++;
`ifdef LONG_PRESS_CLEAR_EN
                n_cmp++;
                if (i != 27 || digit_valid !== 1'b0 || overrun !== 1'b0) begin
                    n_bad++; $display("FAIL long_clear_edge: got cyc=%0d valid=%b expected cyc=27 valid=0", i, digit_valid);
                end
`endif
            end
        end
        n_cmp++;
`ifdef LONG_PRESS_CLEAR_EN
        if (clears != 1) begin n_bad++; $display("FAIL long_clear_count: got %0d expected 1", clears); end
`else
        if (clears != 0) begin n_bad++; $display("FAIL long_clear_count: got %0d expected 0", clears); end
`endif
        for (int i = 0; i < 8; i++) cycle(1'b1, 4'd0, 1'b1);
    endtask

    task automatic test_reset_mid();
        for (int phase = 0; phase < 2; phase++) begin
            for (int i = 0; i < ((phase == 0) ? 4 : 9); i++) cycle(1'b0, 4'd8, 1'b0);
            reset = 1'b1;
            #1;
            n_cmp++;
            if (obs !== 9'h000) begin n_bad++; $display("FAIL reset_mid_async ph%0d: got %h expected 000", phase, obs); end
            model_reset();
            @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            for (int i = 1; i <= 7; i++) begin
                cycle(1'b0, 4'd8, 1'b0);
                n_cmp++;
                if (obs !== expv) begin n_bad++; $display("FAIL reset_mid ph%0d cyc %0d: got %h expected %h", phase, i, obs, expv); end
            end
            n_cmp++;
            if ({digit, digit_valid} !== 5'b1000_1) begin n_bad++; $display("FAIL reset_mid_digit ph%0d: got %b expected 10001", phase, {digit, digit_valid}); end
        end
        for (int i = 0; i < 8; i++) cycle(1'b1, 4'd0, 1'b1);
    endtask

    task automatic test_random();
        int seg = 0;
        logic lvl = 1'b1;
        logic [3:0] num = '0;
        for (int i = 0; i < 3000; i++) begin
            if (seg == 0) begin
                lvl = ~lvl;
                seg = int'($urandom_range(1, 12));
                num = 4'($urandom_range(0, 15));
            end
            seg--;
            cycle(lvl, num, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
            n_cmp++;
            if (obs !== expv) begin n_bad++; $display("FAIL random cyc %0d: got %h expected %h", i, obs, expv); end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_reject();
        test_overrun();
        test_long_press();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
